tf330_bus_arbiter: RTL and testbench
====================================

Name: tf330_bus_arbiter

Overview:
- Sequences bus mastership of the 68030 local bus between the CPU and two external DMA masters: the CD32/motherboard side (BR20/BG20/BGACK20) and the expansion port (EXP_BR/EXP_BG/EXP_BGACK).
- Acts as the single bus requester toward the 68030. Forwards one winning request at a time, drives BGACK30 on the winner's behalf, and returns the bus to the CPU between tenures.
- Sits in the main CPLD beside the SDRAM and IDE logic, clocked from CLKCPU.

Parameters:
- SYNC_STAGES, 2: flop stages on every asynchronous input.
- GRANT_TIMEOUT, 255: CLKCPU cycles to wait for the winner's BGACK after grant before abandoning the grant.
- CPU_HOLD, 4: minimum cycles the CPU keeps the bus after a release before the next grant may start.

Ports:
- CLKCPU  in  1  CPU clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- BR20  in  1  motherboard bus request, active-low.
- BGACK20  in  1  motherboard bus-grant acknowledge, active-low.
- EXP_BR  in  1  expansion bus request, active-low.
- EXP_BGACK  in  1  expansion bus-grant acknowledge, active-low.
- BG30  in  1  68030 bus grant, active-low.
- AS30  in  1  68030 address strobe, active-low.
- BR30  out  1  request to 68030, active-low.
- BGACK30  out  1  grant acknowledge to 68030, active-low.
- BG20  out  1  grant to motherboard, active-low.
- EXP_BG  out  1  grant to expansion, active-low.
- OWNER  out  2  current owner: 00 CPU, 01 motherboard, 10 expansion.
- GRANT_TO  out  1  one-cycle pulse when a grant times out.

Behaviour:
- Reset values:
  - BR30, BGACK30, BG20, EXP_BG = 1.
  - OWNER = 00; GRANT_TO = 0.
  - State = IDLE; hold counter = 0.
  - last_owner = expansion, so the motherboard wins the first tie.
- Input synchronisation:
  - Every input except RESET passes through SYNC_STAGES flops.
  - All cycle counts below are from the synchronised value.
- IDLE:
  - Arbitration waits while the hold counter is non-zero; the counter decrements each cycle.
  - When a synchronised request (BR20 or EXP_BR) is low, latch the winner. With both low, the winner is the master that is not last_owner.
  - Next edge: BR30 = 0, go to REQ.
- REQ:
  - If the winner's BR goes high before the grant (request withdrawn): BR30 = 1, go to IDLE. No grant is issued.
  - When BG30 = 0 and AS30 = 1, on the next edge:
    - BGACK30 = 0.
    - Winner's grant (BG20 or EXP_BG) = 0.
    - OWNER = winner code.
    - Timeout counter cleared; go to GRANT.
- GRANT:
  - When the winner's BGACK = 0:
    - Negate the winner's grant and BR30 (BGACK30 stays low).
    - Go to OWNED.
  - When the timeout counter reaches GRANT_TIMEOUT first:
    - Negate the grant, BR30 and BGACK30.
    - GRANT_TO = 1 for one cycle; go to RELEASE.
  - The counter saturates and never wraps.
- OWNED:
  - Hold BGACK30 = 0 while the winner's BGACK = 0.
  - The other master's request is ignored.
  - Winner's BGACK high: go to RELEASE.
- RELEASE (exactly one cycle):
  - All outputs negated; OWNER = 00.
  - last_owner = winner; hold counter = CPU_HOLD.
  - Go to IDLE.
- Invariants:
  - At most one of BG20 and EXP_BG is low at any time.
  - BGACK30 is low only in GRANT and OWNED.
- RESET asserted in any state: all outputs return to reset values on that edge. No RELEASE cycle is inserted.

Decomposition:
- Package tf330_arb_pkg holds:
  - the state enum (IDLE, REQ, GRANT, OWNED, RELEASE);
  - the OWNER codes (OWN_CPU = 00, OWN_MB = 01, OWN_EXP = 10).
- One sub-module, tf_sync: a parameterised SYNC_STAGES-deep synchroniser with reset value 1, instantiated once per input.

Test Plan:
- Motherboard only: BR20 low; BG30 driven low 3 cycles after BR30 falls, AS30 high; BGACK20 low 2 cycles after BG20 falls.
  - BR30 = 0 at sync+1.
  - BG20 and BGACK30 = 0 one cycle after BG30 sync; OWNER = 01.
  - BG20 and BR30 = 1 once BGACK20 sync is seen.
  - BGACK20 high gives a RELEASE cycle with OWNER = 00.
- Simultaneous BR20 and EXP_BR low from reset:
  - Motherboard granted first. After its release and CPU_HOLD = 4 idle cycles, EXP_BG = 0 and OWNER = 10.
  - BG20 and EXP_BG never both low.
- BG30 low while AS30 low for 5 cycles: no grant issued until the cycle after AS30 sync goes high.
- EXP_BR low, never assert EXP_BGACK:
  - After 255 cycles in GRANT: EXP_BG, BR30 and BGACK30 = 1; GRANT_TO pulses once.
  - Then OWNER = 00 and the hold period runs.
- BR20 withdrawn in REQ before BG30: BR30 returns to 1 the next cycle; BG20 never asserted.
- RESET pulsed during OWNED: all outputs at reset values on that edge; the next request proceeds normally from IDLE.

Source files
------------

// File: rtl/tf330_arb_pkg.sv
// tf330_arb_pkg: shared state encoding and bus-owner codes for the TF330 bus arbiter
package tf330_arb_pkg;
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_GRANT   = 3'd2,
      ST_OWNED   = 3'd3,
      ST_RELEASE = 3'd4
   } arb_state_t;
   localparam logic [1:0] OWN_CPU = 2'b00;
   localparam logic [1:0] OWN_MB  = 2'b01;
   localparam logic [1:0] OWN_EXP = 2'b10;
endpackage

// File: rtl/tf_sync.sv
// tf_sync: STAGES-deep flop synchroniser for one asynchronous, idle-high input
module tf_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '1;
      else     sync_q <= (sync_q << 1) | STAGES'(d_i);
   end
   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/tf330_bus_arbiter.sv
// tf330_bus_arbiter: hands the 68030 bus to the motherboard or expansion DMA master,
// one tenure at a time, and gives it back to the CPU for CPU_HOLD cycles in between.
module tf330_bus_arbiter
   import tf330_arb_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int GRANT_TIMEOUT = 255,
   parameter int CPU_HOLD      = 4
) (
   input  logic       CLKCPU,
   input  logic       RESET,
   input  logic       BR20,
   input  logic       BGACK20,
   input  logic       EXP_BR,
   input  logic       EXP_BGACK,
   input  logic       BG30,
   input  logic       AS30,
   output logic       BR30,
   output logic       BGACK30,
   output logic       BG20,
   output logic       EXP_BG,
   output logic [1:0] OWNER,
   output logic       GRANT_TO
);
   localparam int TW = $clog2(GRANT_TIMEOUT + 1);
   localparam int HW = $clog2(CPU_HOLD + 2);
   logic [5:0] raw, syn;
   logic br20_s, bgack20_s, exp_br_s, exp_bgack_s, bg30_s, as30_s;
   assign raw = {BR20, BGACK20, EXP_BR, EXP_BGACK, BG30, AS30};
   for (genvar i = 0; i < 6; i++) begin : g_sync
      tf_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk(CLKCPU),
         .rst(RESET),
         .d_i(raw[i]),
         .q_o(syn[i])
      );
   end
   assign {br20_s, bgack20_s, exp_br_s, exp_bgack_s, bg30_s, as30_s} = syn;
   arb_state_t    state_q, state_d;
   logic          win_q, win_d;
   logic          last_q, last_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [TW-1:0] to_q, to_d;
   logic          gto_q, gto_d;
   logic          win_br, win_bgack;
   // win/last: 0 = motherboard, 1 = expansion
   assign win_br    = win_q ? exp_br_s : br20_s;
   assign win_bgack = win_q ? exp_bgack_s : bgack20_s;
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      last_d  = last_q;
      hold_d  = hold_q;
      to_d    = to_q;
      gto_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (hold_q != '0) hold_d = hold_q - 1'b1;
            else if (!br20_s || !exp_br_s) begin
               win_d   = (!br20_s && !exp_br_s) ? !last_q : br20_s;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (win_br) state_d = ST_IDLE;
            else if (!bg30_s && as30_s) begin
               to_d    = '0;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!win_bgack) state_d = ST_OWNED;
            else if (to_q == TW'(GRANT_TIMEOUT - 1)) begin
               gto_d   = 1'b1;
               state_d = ST_RELEASE;
            end else to_d = to_q + 1'b1;
         end
         ST_OWNED: state_d = win_bgack ? ST_RELEASE : ST_OWNED;
         ST_RELEASE: begin
            last_d  = win_q;
            hold_d  = HW'(CPU_HOLD);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge CLKCPU) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         win_q   <= 1'b0;
         last_q  <= 1'b1;
         hold_q  <= '0;
         to_q    <= '0;
         gto_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         to_q    <= to_d;
         gto_q   <= gto_d;
      end
   end
   assign BR30     = !(state_q == ST_REQ || state_q == ST_GRANT);
   assign BGACK30  = !(state_q == ST_GRANT || state_q == ST_OWNED);
   assign BG20     = !(state_q == ST_GRANT && !win_q);
   assign EXP_BG   = !(state_q == ST_GRANT && win_q);
   assign OWNER    = (state_q == ST_GRANT || state_q == ST_OWNED) ? (win_q ? OWN_EXP : OWN_MB) : OWN_CPU;
   assign GRANT_TO = gto_q;
endmodule

// File: tb/tb_tf330_bus_arbiter.sv
// tb_tf330_bus_arbiter: directed and randomized checks of the TF330 bus arbiter against a tenure-level model
module tb_tf330_bus_arbiter;
   localparam int SS = 2;
   localparam int GT = 255;
   localparam int CH = 4;
   logic clk = 1'b0;
   logic RESET = 1'b1;
   logic BR20 = 1'b1, BGACK20 = 1'b1, EXP_BR = 1'b1, EXP_BGACK = 1'b1, BG30 = 1'b1, AS30 = 1'b1;
   logic BR30, BGACK30, BG20, EXP_BG, GRANT_TO;
   logic [1:0] OWNER;
   logic [6:0] outs;
   int compared = 0;
   int mismatched = 0;
   always #5 clk = ~clk;
   tf330_bus_arbiter #(.SYNC_STAGES(SS), .GRANT_TIMEOUT(GT), .CPU_HOLD(CH)) dut (
      .CLKCPU(clk), .RESET(RESET), .BR20(BR20), .BGACK20(BGACK20), .EXP_BR(EXP_BR),
      .EXP_BGACK(EXP_BGACK), .BG30(BG30), .AS30(AS30), .BR30(BR30), .BGACK30(BGACK30),
      .BG20(BG20), .EXP_BG(EXP_BG), .OWNER(OWNER), .GRANT_TO(GRANT_TO)
   );
   // bit order: BR30 BGACK30 BG20 EXP_BG OWNER[1:0] GRANT_TO
   assign outs = {BR30, BGACK30, BG20, EXP_BG, OWNER, GRANT_TO};

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Tenure-level model: who holds the bus and which phase of the handover it is in.
   logic [5:0] hist[$];
   logic [5:0] s;
   bit model_ok = 0;
   int who, last, age, hold_left;
   bit asking, given, held, closing, timed;
   always @(posedge clk) begin
      if (RESET) begin
         hist.delete();
         for (int k = 0; k < SS; k++) hist.push_back(6'h3f);
         who = 0; last = 2; age = 0; hold_left = 0;
         asking = 0; given = 0; held = 0; closing = 0; timed = 0;
         model_ok = 1;
      end else if (model_ok) begin
         bit mb_br, mb_ack, ex_br, ex_ack, w_br, w_ack;
         s = hist.pop_front();
         hist.push_back({BR20, BGACK20, EXP_BR, EXP_BGACK, BG30, AS30});
         {mb_br, mb_ack, ex_br, ex_ack} = s[5:2];
         w_br  = (who == 1) ? mb_br : ex_br;
         w_ack = (who == 1) ? mb_ack : ex_ack;
         if (closing) begin
            closing = 0; timed = 0; last = who; who = 0; hold_left = CH;
         end else if (held) begin
            if (w_ack) begin held = 0; closing = 1; end
         end else if (given) begin
            if (!w_ack) begin given = 0; held = 1; end
            else if (age + 1 == GT) begin given = 0; closing = 1; timed = 1; end
            else age++;
         end else if (asking) begin
            if (w_br) begin asking = 0; who = 0; end
            else if (!s[1] && s[0]) begin asking = 0; given = 1; age = 0; end
         end else if (hold_left > 0) hold_left--;
         else if (!mb_br || !ex_br) begin
            who = (!mb_br && !ex_br) ? ((last == 1) ? 2 : 1) : (!mb_br ? 1 : 2);
            asking = 1;
         end
      end
   end

   function automatic logic [6:0] model_outs();
      return {!(asking || given), !(given || held), !(given && who == 1), !(given && who == 2),
              (given || held) ? 2'(who) : 2'b00, closing && timed};
   endfunction

   always @(negedge clk) begin
      if (model_ok) begin
         check("outputs vs model", int'(outs), int'(model_outs()));
         check("single grant", int'(BG20 | EXP_BG), 1);
      end
   end

   task automatic wait_bit(input int b, input logic v, input int max, output int n);
      n = 0;
      while (outs[b] !== v && n < max) begin
         @(negedge clk);
         n++;
      end
      if (outs[b] !== v) n = -1;
   endtask

   task automatic master(input logic gnt, inout logic br, inout logic ack, inout int dly, inout int hold);
      if (hold > 0) begin
         hold--;
         if (hold == 0) begin ack = 1'b1; br = 1'b1; end
      end else if (dly > 0) begin
         dly--;
         if (dly == 0) begin ack = 1'b0; hold = $urandom_range(1, 8); end
      end else if (!gnt) dly = ($urandom_range(0, 14) == 0) ? 300 : $urandom_range(1, 4);
      else if (br && $urandom_range(0, 7) == 0) br = 1'b0;
      else if (!br && $urandom_range(0, 29) == 0) br = 1'b1;
   endtask

   initial begin
      int n, mb_d, mb_h, ex_d, ex_h, bg_d;
      repeat (3) @(negedge clk);
      check("reset outputs", int'(outs), int'(7'b1111000));
      RESET = 1'b0;
      // motherboard alone
      BR20 = 1'b0;
      wait_bit(6, 1'b0, 20, n); check("mb BR30 latency", n, 3);
      repeat (3) @(negedge clk);
      BG30 = 1'b0;
      wait_bit(4, 1'b0, 20, n); check("mb BG20 latency", n, 3);
      check("mb OWNER", int'(OWNER), 1);
      check("mb BGACK30", int'(BGACK30), 0);
      repeat (2) @(negedge clk);
      BGACK20 = 1'b0; BR20 = 1'b1;
      wait_bit(4, 1'b1, 20, n); check("mb BG20 release", n, 3);
      check("mb BR30 after ack", int'(BR30), 1);
      BGACK20 = 1'b1;
      wait_bit(5, 1'b1, 20, n); check("mb release latency", n, 3);
      check("mb release OWNER", int'(OWNER), 0);
      // simultaneous requests from reset: motherboard wins the tie
      RESET = 1'b1; @(negedge clk); RESET = 1'b0;
      BR20 = 1'b0; EXP_BR = 1'b0; BG30 = 1'b0; AS30 = 1'b1;
      wait_bit(4, 1'b0, 20, n); check("tie mb first", n >= 0, 1);
      check("tie exp not granted", int'(EXP_BG), 1);
      BGACK20 = 1'b0; BR20 = 1'b1;
      wait_bit(4, 1'b1, 20, n);
      BGACK20 = 1'b1;
      wait_bit(5, 1'b1, 20, n);
      wait_bit(3, 1'b0, 40, n); check("tie exp after hold", n, 7);
      check("tie exp OWNER", int'(OWNER), 2);
      EXP_BGACK = 1'b0; EXP_BR = 1'b1;
      wait_bit(3, 1'b1, 20, n);
      EXP_BGACK = 1'b1;
      wait_bit(5, 1'b1, 20, n);
      // CPU address strobe active delays the grant
      AS30 = 1'b0; BR20 = 1'b0;
      wait_bit(6, 1'b0, 20, n);
      repeat (5) @(negedge clk);
      check("as30 blocks grant", int'(BG20), 1);
      AS30 = 1'b1;
      wait_bit(4, 1'b0, 20, n); check("grant after as30", n, 3);
      BGACK20 = 1'b0; BR20 = 1'b1;
      wait_bit(4, 1'b1, 20, n);
      BGACK20 = 1'b1;
      wait_bit(5, 1'b1, 20, n);
      // expansion never acknowledges
      EXP_BR = 1'b0;
      wait_bit(3, 1'b0, 30, n);
      wait_bit(3, 1'b1, 400, n); check("timeout length", n, GT);
      check("timeout pulse", int'(GRANT_TO), 1);
      check("timeout outs", int'(outs), int'(7'b1111001));
      EXP_BR = 1'b1;
      @(negedge clk);
      check("timeout pulse ends", int'(GRANT_TO), 0);
      // request withdrawn before the CPU grants
      BG30 = 1'b1; BR20 = 1'b0;
      wait_bit(6, 1'b0, 30, n);
      BR20 = 1'b1;
      wait_bit(6, 1'b1, 20, n); check("withdraw latency", n, 3);
      check("withdraw no grant", int'(BG20), 1);
      // reset during an owned tenure
      BG30 = 1'b0; BR20 = 1'b0;
      wait_bit(4, 1'b0, 30, n);
      BGACK20 = 1'b0; BR20 = 1'b1;
      wait_bit(4, 1'b1, 20, n);
      check("owned before reset", int'(OWNER), 1);
      RESET = 1'b1;
      @(negedge clk);
      check("reset in owned", int'(outs), int'(7'b1111000));
      RESET = 1'b0; BGACK20 = 1'b1; BR20 = 1'b0;
      wait_bit(4, 1'b0, 20, n); check("grant after reset", n, 4);
      BGACK20 = 1'b0; BR20 = 1'b1;
      wait_bit(4, 1'b1, 20, n);
      BGACK20 = 1'b1;
      wait_bit(5, 1'b1, 20, n);
      BG30 = 1'b1;
      // randomized reactive masters and CPU
      mb_d = 0; mb_h = 0; ex_d = 0; ex_h = 0; bg_d = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         master(BG20, BR20, BGACK20, mb_d, mb_h);
         master(EXP_BG, EXP_BR, EXP_BGACK, ex_d, ex_h);
         if (BR30) begin
            BG30 = 1'b1;
            bg_d = $urandom_range(1, 4);
         end else if (bg_d > 0) begin
            bg_d--;
            if (bg_d == 0) BG30 = 1'b0;
         end
         AS30 = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
